writeback_mux_arb: RTL and testbench
====================================

# writeback_mux_arb

Parametrised writeback stage for the RISC-V pipeline. Merges the in-order W-stage result (ALU / load / PC+4, with load byte/halfword extraction) with NUM_LL long-latency result channels (e.g. mul/div) onto the single register-file write port. The port is registered. Each long-latency channel is buffered in its own small FIFO with a valid/ready handshake. Sits between the memory stage pipeline register and the register file / forwarding unit.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NUM_LL, 2, number of long-latency channels (1..4).
- LL_DEPTH, 2, entries per long-latency FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWrite_W  in  1  in-order write enable.
- ResultSrc_W  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved.
- RD_W  in  5  in-order destination.
- PCPlus4_W, ALU_Result_W, ReadData_W  in  XLEN  in-order sources.
- LoadFunct3_W  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- ll_valid  in  NUM_LL  per-channel result valid.
- ll_ready  out  NUM_LL  per-channel FIFO not full.
- ll_rd  in  5*NUM_LL  per-channel destination; channel i at [5i+4:5i].
- ll_data  in  XLEN*NUM_LL  per-channel result; channel i at [XLEN*i +: XLEN].
- ll_pending  out  NUM_LL  FIFO i non-empty (for the hazard scoreboard).
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_data  out  XLEN  register-file write data.

## Operation
- In-order result (combinational): ResultSrc 00→ALU_Result_W, 01→extended load, 10→PCPlus4_W, 11→0.
- Load extension: byte offset = ALU_Result_W[1:0]; LB/LBU select byte at offset, LH/LHU select halfword at offset[1]; sign- or zero-extend to XLEN; LW and undefined funct3 pass ReadData_W unchanged.
- In-order request is active when RegWrite_W=1 and RD_W≠0. It always wins the port and is never stalled.
- Long-latency push: a beat is accepted when ll_valid[i] & ll_ready[i]. Beats with rd=0 are accepted and discarded (not enqueued).
- Arbitration: when no in-order request is active, grant one non-empty FIFO by round-robin. Search starts at rr_ptr. After a grant to channel g, rr_ptr ← (g+1) mod NUM_LL. If no channel is granted, rr_ptr holds.
- The granted FIFO pops and its head drives the write port.

## Timing
- Reset (rst=0, async): wb_we=0, wb_rd=0, wb_data=0, all FIFOs empty, ll_pending=0, ll_ready=all 1, rr_ptr=0.
- Latency: in-order request in cycle N → wb_* valid in cycle N+1. A long-latency beat accepted in cycle N is earliest on wb_* in N+2 (enqueue, then pop).
- wb_we=0 in any cycle without a grant. wb_rd and wb_data then hold their last values.
- ll_ready[i] = (count_i < LL_DEPTH), from registered state only. It does not depend on ll_valid or on a same-cycle pop, so a full FIFO deasserts ready even when popping.
- Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved (FIFO).
- Pointer wrap at LL_DEPTH is modulo. Count width is $clog2(LL_DEPTH)+1.
- A sustained in-order stream starves the long-latency channels. This is intended: the upstream issue logic guarantees gaps.
- Reset asserted mid-operation discards all buffered results immediately.

## Configuration
- WB_LOAD_EXT_EN defined: byte/halfword extraction and sign/zero extension as described.
- Not defined: ResultSrc 01 selects ReadData_W unmodified. LoadFunct3_W and ALU_Result_W[1:0] are ignored for the result, and the memory stage performs extension.

## Structure
- Package wb_pkg holds the ResultSrc encodings (RES_ALU, RES_LOAD, RES_PC4), the load funct3 constants, and the XLEN default.
- Sub-module wb_fifo (parameters WIDTH, DEPTH) is instantiated once per channel via generate, with WIDTH=5+XLEN. It provides push/pop/full/empty/count.
- The top level contains the result mux, load extension, round-robin arbiter and output register.

## Test plan
- Reset: hold rst=0, drive all inputs active → wb_we=0, wb_data=0, ll_ready=all 1, ll_pending=0; release and check first-cycle behaviour.
- Load extension (macro on): ReadData_W=0x8000_80F0, ALU_Result_W[1:0]=01, LB → 0xFFFF_FF80; LBU → 0x0000_0080. Offset 10 with LH → 0xFFFF_8000.
- Priority: in-order write rd=5 and channel 0 beat rd=7 in the same cycle → rd=5 written at N+1, rd=7 at N+2.
- Round-robin: both channels hold 2 entries (rd 1,2 and 3,4) with no in-order traffic → write order 1,3,2,4.
- Full FIFO: push 2 beats into channel 1 while in-order traffic is continuous → ll_ready[1]=0 and a third beat is not accepted. Drop RegWrite_W → drain, ready reasserts the cycle after the first pop.
- x0 filtering: in-order RD_W=0 and long-latency rd=0 beats → wb_we stays 0, and ll_pending stays 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3 codes, widths.
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering one long-latency result channel; DEPTH must be a power of two.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: storage is not reset; the pointers and count are, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = push_i ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop_i  ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/writeback_mux_arb.sv
// Writeback stage: in-order result mux plus round-robin merge of long-latency FIFOs onto one
// registered register-file write port. Define WB_LOAD_EXT_EN to extract/extend sub-word loads here.
module writeback_mux_arb
    import wb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_LL   = 2,
    parameter int LL_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RegWrite_W,
    input  logic [1:0]                   ResultSrc_W,
    input  logic [REG_ADDR_W-1:0]        RD_W,
    input  logic [XLEN-1:0]              PCPlus4_W,
    input  logic [XLEN-1:0]              ALU_Result_W,
    input  logic [XLEN-1:0]              ReadData_W,
    input  logic [2:0]                   LoadFunct3_W,
    input  logic [NUM_LL-1:0]            ll_valid,
    output logic [NUM_LL-1:0]            ll_ready,
    input  logic [REG_ADDR_W*NUM_LL-1:0] ll_rd,
    input  logic [XLEN*NUM_LL-1:0]       ll_data,
    output logic [NUM_LL-1:0]            ll_pending,
    output logic                         wb_we,
    output logic [REG_ADDR_W-1:0]        wb_rd,
    output logic [XLEN-1:0]              wb_data
);

    localparam int ENTRY_W = REG_ADDR_W + XLEN;
    localparam int CNT_W   = $clog2(LL_DEPTH) + 1;
    localparam int RR_W    = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;

    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] inorder_data;
    logic            inorder_req;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (ALU_Result_W[1:0])
            2'd0:    byte_sel = ReadData_W[7:0];
            2'd1:    byte_sel = ReadData_W[15:8];
            2'd2:    byte_sel = ReadData_W[23:16];
            default: byte_sel = ReadData_W[31:24];
        endcase
        half_sel = ALU_Result_W[1] ? ReadData_W[31:16] : ReadData_W[15:0];
    end

    always_comb begin
        case (LoadFunct3_W)
            F3_LB:   load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  load_val = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   load_val = ReadData_W;
            default: load_val = ReadData_W;
        endcase
    end
`else
    // Memory stage already extended the load; funct3 has no effect on the result here.
    logic unused_load_ctl;
    assign unused_load_ctl = ^LoadFunct3_W;
    assign load_val        = ReadData_W;
`endif

    always_comb begin
        inorder_data = '0;
        case (res_src_e'(ResultSrc_W))
            RES_ALU:  inorder_data = ALU_Result_W;
            RES_LOAD: inorder_data = load_val;
            RES_PC4:  inorder_data = PCPlus4_W;
            RES_RSVD: inorder_data = '0;
            default:  inorder_data = '0;
        endcase
    end

    assign inorder_req = RegWrite_W && (RD_W != '0);

    logic [NUM_LL-1:0] push, pop, full, empty;
    logic [ENTRY_W-1:0] head [NUM_LL];
    logic [CNT_W-1:0]   count [NUM_LL];

    for (genvar i = 0; i < NUM_LL; i++) begin : g_ll
        // Writes to x0 are accepted from the producer but never enqueued.
        assign push[i] = ll_valid[i] && !full[i] && (ll_rd[REG_ADDR_W*i +: REG_ADDR_W] != '0);

        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (LL_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .wdata_i ({ll_rd[REG_ADDR_W*i +: REG_ADDR_W], ll_data[XLEN*i +: XLEN]}),
            .rdata_o (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (count[i])
        );

        assign ll_ready[i]   = (count[i] < CNT_W'(LL_DEPTH));
        assign ll_pending[i] = !empty[i];
    end

    logic [RR_W-1:0] rr_q, rr_d;
    logic [RR_W-1:0] grant_idx;
    logic            grant_vld;
    int              idx;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!inorder_req) begin
            for (int k = 0; k < NUM_LL; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_LL) idx = idx - NUM_LL;
                if (!grant_vld && !empty[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = RR_W'(idx);
                end
            end
        end
        pop  = NUM_LL'(grant_vld) << grant_idx;
        rr_d = rr_q;
        if (grant_vld) rr_d = (grant_idx == RR_W'(NUM_LL - 1)) ? '0 : grant_idx + RR_W'(1);
    end

    logic                  wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]       wb_data_q;

    // Address and data hold their last value on idle cycles; only the enable drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wb_we_q <= inorder_req || grant_vld;
            if (inorder_req) begin
                wb_rd_q   <= RD_W;
                wb_data_q <= inorder_data;
            end else if (grant_vld) begin
                {wb_rd_q, wb_data_q} <= head[grant_idx];
            end
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_writeback_mux_arb.sv
// Self-checking bench for writeback_mux_arb: directed test-plan steps, then random traffic
// checked against a queue-based reference model.
module tb_writeback_mux_arb;

    localparam int XLEN     = 32;
    localparam int NUM_LL   = 2;
    localparam int LL_DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   RegWrite_W;
    logic [1:0]             ResultSrc_W;
    logic [4:0]             RD_W;
    logic [XLEN-1:0]        PCPlus4_W, ALU_Result_W, ReadData_W;
    logic [2:0]             LoadFunct3_W;
    logic [NUM_LL-1:0]      ll_valid, ll_ready, ll_pending;
    logic [5*NUM_LL-1:0]    ll_rd;
    logic [XLEN*NUM_LL-1:0] ll_data;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;

    writeback_mux_arb #(.XLEN(XLEN), .NUM_LL(NUM_LL), .LL_DEPTH(LL_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWrite_W   (RegWrite_W),
        .ResultSrc_W  (ResultSrc_W),
        .RD_W         (RD_W),
        .PCPlus4_W    (PCPlus4_W),
        .ALU_Result_W (ALU_Result_W),
        .ReadData_W   (ReadData_W),
        .LoadFunct3_W (LoadFunct3_W),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_rd        (ll_rd),
        .ll_data      (ll_data),
        .ll_pending   (ll_pending),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one queue of {rd, data} per channel, plus expected port values.
    logic [36:0]     mq [NUM_LL][$];
    int              rr;
    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc4);
        logic [31:0] ld;
`ifdef WB_LOAD_EXT_EN
        int          off;
        logic [31:0] b, h;
        off = int'(alu[1:0]);
        b   = (rdata >> (8 * off)) & 32'hFF;
        h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  ld = b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  ld = b;
            3'b001:  ld = h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  ld = h;
            default: ld = rdata;
        endcase
`else
        ld = rdata;
`endif
        case (src)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return pc4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_LL; i++) mq[i].delete();
        rr       = 0;
        exp_we   = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    task automatic idle();
        RegWrite_W   = 1'b0;
        ResultSrc_W  = 2'b00;
        RD_W         = '0;
        PCPlus4_W    = '0;
        ALU_Result_W = '0;
        ReadData_W   = '0;
        LoadFunct3_W = 3'b010;
        ll_valid     = '0;
        ll_rd        = '0;
        ll_data      = '0;
    endtask

    task automatic set_ll(input int ch, input logic v, input logic [4:0] rd, input logic [31:0] d);
        ll_valid[ch]         = v;
        ll_rd[5*ch +: 5]     = rd;
        ll_data[XLEN*ch +: XLEN] = d;
    endtask

    // One clock: check ready/pending, advance the model with the current inputs, check wb_*.
    task automatic step();
        logic [NUM_LL-1:0] exp_ready, exp_pend, acc;
        logic              inorder;
        logic [31:0]       in_res;
        int                g;
        for (int i = 0; i < NUM_LL; i++) begin
            exp_ready[i] = mq[i].size() < LL_DEPTH;
            exp_pend[i]  = mq[i].size() > 0;
            acc[i]       = ll_valid[i] && exp_ready[i] && (ll_rd[5*i +: 5] != 0);
        end
        check("ll_ready", ll_ready, exp_ready);
        check("ll_pending", ll_pending, exp_pend);
        inorder = RegWrite_W && (RD_W != 0);
        in_res  = ref_result(ResultSrc_W, LoadFunct3_W, ALU_Result_W, ReadData_W, PCPlus4_W);
        g = -1;
        if (!inorder) begin
            for (int k = 0; k < NUM_LL; k++) begin
                if (g < 0 && mq[(rr + k) % NUM_LL].size() > 0) g = (rr + k) % NUM_LL;
            end
        end
        if (inorder) begin
            exp_we   = 1'b1;
            exp_rd   = RD_W;
            exp_data = in_res;
        end else if (g >= 0) begin
            {exp_rd, exp_data} = mq[g].pop_front();
            exp_we = 1'b1;
            rr     = (g + 1) % NUM_LL;
        end else begin
            exp_we = 1'b0;
        end
        for (int i = 0; i < NUM_LL; i++)
            if (acc[i]) mq[i].push_back({ll_rd[5*i +: 5], ll_data[XLEN*i +: XLEN]});
        @(posedge clk);
        #1;
        check("wb_we", wb_we, exp_we);
        check("wb_rd", wb_rd, exp_rd);
        check("wb_data", wb_data, exp_data);
    endtask

    initial begin
        logic [4:0] order [4];

        // Reset with every input active: outputs must stay in their reset state.
        idle();
        rst        = 1'b0;
        RegWrite_W = 1'b1;
        RD_W       = 5'd5;
        ALU_Result_W = 32'hDEAD_BEEF;
        set_ll(0, 1'b1, 5'd3, 32'h1111);
        set_ll(1, 1'b1, 5'd4, 32'h2222);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", wb_we, 1'b0);
        check("rst_rd", wb_rd, 5'd0);
        check("rst_data", wb_data, 32'h0);
        check("rst_ready", ll_ready, 2'b11);
        check("rst_pending", ll_pending, 2'b00);

        // First cycle after release: in-order write and both channel beats.
        rst = 1'b1;
        step();
        check("first_rd", wb_rd, 5'd5);
        idle();
        step();
        step();
        step();

        // Load extension.
        RegWrite_W   = 1'b1;
        RD_W         = 5'd3;
        ResultSrc_W  = 2'b01;
        ReadData_W   = 32'h8000_80F0;
        ALU_Result_W = 32'h0000_1001;
        LoadFunct3_W = 3'b000;
        step();
`ifdef WB_LOAD_EXT_EN
        check("lb_off1", wb_data, 32'hFFFF_FF80);
`else
        check("lb_raw", wb_data, 32'h8000_80F0);
`endif
        LoadFunct3_W = 3'b100;
        step();
`ifdef WB_LOAD_EXT_EN
        check("lbu_off1", wb_data, 32'h0000_0080);
`endif
        ALU_Result_W = 32'h0000_1002;
        LoadFunct3_W = 3'b001;
        step();
`ifdef WB_LOAD_EXT_EN
        check("lh_off2", wb_data, 32'hFFFF_8000);
`endif
        ResultSrc_W = 2'b10;
        PCPlus4_W   = 32'h0000_0104;
        step();
        ResultSrc_W = 2'b11;
        step();
        check("rsvd_zero", wb_data, 32'h0);

        // Priority: in-order rd=5 beats a same-cycle channel-0 beat rd=7.
        idle();
        RegWrite_W   = 1'b1;
        RD_W         = 5'd5;
        ALU_Result_W = 32'h55;
        set_ll(0, 1'b1, 5'd7, 32'h77);
        step();
        check("prio_first", wb_rd, 5'd5);
        idle();
        step();
        check("prio_second", wb_rd, 5'd7);
        check("prio_second_we", wb_we, 1'b1);
        step();

        // Reset mid-operation discards buffered results at once.
        RegWrite_W = 1'b1;
        RD_W       = 5'd6;
        set_ll(0, 1'b1, 5'd8, 32'h88);
        set_ll(1, 1'b1, 5'd9, 32'h99);
        step();
        idle();
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_pending", ll_pending, 2'b00);
        check("midrst_we", wb_we, 1'b0);
        check("midrst_ready", ll_ready, 2'b11);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin: ch0 holds rd 1,2 and ch1 holds rd 3,4 -> order 1,3,2,4.
        RegWrite_W   = 1'b1;
        RD_W         = 5'd9;
        ALU_Result_W = 32'h9;
        set_ll(0, 1'b1, 5'd1, 32'h101);
        set_ll(1, 1'b1, 5'd3, 32'h303);
        step();
        set_ll(0, 1'b1, 5'd2, 32'h202);
        set_ll(1, 1'b1, 5'd4, 32'h404);
        step();
        idle();
        for (int n = 0; n < 4; n++) begin
            step();
            order[n] = wb_rd;
        end
        check("rr_0", order[0], 5'd1);
        check("rr_1", order[1], 5'd3);
        check("rr_2", order[2], 5'd2);
        check("rr_3", order[3], 5'd4);
        step();

        // Full FIFO on channel 1 under continuous in-order traffic.
        RegWrite_W   = 1'b1;
        RD_W         = 5'd20;
        ALU_Result_W = 32'h20;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) check("full_ready_low", ll_ready[1], 1'b0);
            set_ll(1, 1'b1, 5'(10 + n), 32'(32'hA0 + n));
            step();
        end
        idle();
        step();
        check("drain_first_rd", wb_rd, 5'd10);
        check("ready_reasserts", ll_ready[1], 1'b1);
        step();
        check("drain_second_rd", wb_rd, 5'd11);
        step();
        check("no_third_beat", wb_we, 1'b0);

        // x0 filtering on both paths.
        RegWrite_W = 1'b1;
        RD_W       = 5'd0;
        set_ll(0, 1'b1, 5'd0, 32'hBAD0);
        set_ll(1, 1'b1, 5'd0, 32'hBAD1);
        repeat (3) step();
        check("x0_we", wb_we, 1'b0);
        check("x0_pending", ll_pending, 2'b00);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            RegWrite_W   = ($urandom_range(0, 2) == 0);
            RD_W         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ResultSrc_W  = 2'($urandom_range(0, 3));
            LoadFunct3_W = 3'($urandom_range(0, 7));
            ALU_Result_W = $urandom;
            ReadData_W   = $urandom;
            PCPlus4_W    = $urandom;
            for (int i = 0; i < NUM_LL; i++)
                set_ll(i, ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            step();
        end
        idle();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
